alu_share_arbiter: RTL and testbench

Shares one combinational RV32I ALU between two requesters, for example the main execute path (req0) and a branch/address helper (req1).
- Accepts ALUOp/fun3/fun7 plus operands from each requester using a valid/ready handshake.
- Arbitrates between requesters round-robin.
- Decodes the request into the team's 4-bit ALU control code and drives the shared ALU from registers.
- Captures the ALU result and returns it on the owning requester's response channel.

---
 rtl/alu_share_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational RV32I ALU between two valid/ready requesters.
// Round-robin grant by default; define ALU_ARB_FIXED_PRIORITY_EN to make req0 always win.
module alu_share_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ID_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_aluop,
  input  logic [2:0]      req0_fun3,
  input  logic            req0_fun7,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [ID_W-1:0] req0_id,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_aluop,
  input  logic [2:0]      req1_fun3,
  input  logic            req1_fun7,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [ID_W-1:0] req1_id,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_result,
  output logic            resp0_zero,
  output logic [ID_W-1:0] resp0_id,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_result,
  output logic            resp1_zero,
  output logic [ID_W-1:0] resp1_id,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          state_q, state_d;
  logic            owner_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic [3:0]      ctrl_q;
  logic            zero_q;
  logic [ID_W-1:0] id_q;

  logic            gnt0, gnt1, idle, fire, resp_fire;
  logic [1:0]      s_aluop;
  logic [2:0]      s_fun3;
  logic            s_fun7;
  logic [3:0]      dec;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  assign gnt1 = req1_valid && !req0_valid;
`else
  logic last_grant_q;

  // last_grant resets to 1 so req0 wins the first contested cycle
  assign gnt1 = req1_valid && (!req0_valid || !last_grant_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (fire) begin
      last_grant_q <= gnt1;
    end
  end
`endif

  assign gnt0       = req0_valid && !gnt1;
  assign idle       = (state_q == StIdle);
  assign req0_ready = idle && gnt0;
  assign req1_ready = idle && gnt1;
  assign fire       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign resp_fire  = owner_q ? resp1_ready : resp0_ready;

  assign s_aluop = gnt1 ? req1_aluop : req0_aluop;
  assign s_fun3  = gnt1 ? req1_fun3  : req0_fun3;
  assign s_fun7  = gnt1 ? req1_fun7  : req0_fun7;

  always_comb begin
    dec = 4'b0010;
    case (s_aluop)
      2'b00: begin
        case (s_fun3)
          3'b010:  dec = 4'b0111;
          3'b111:  dec = 4'b0000;
          3'b110:  dec = 4'b0001;
          3'b100:  dec = 4'b1100;
          default: dec = 4'b0010;
        endcase
      end
      2'b01: begin
        case (s_fun3)
          3'b100, 3'b101: dec = 4'b0111;
          default:        dec = 4'b0110;
        endcase
      end
      2'b10: begin
        case (s_fun3)
          3'b000:  dec = s_fun7 ? 4'b0110 : 4'b0010;
          3'b010:  dec = 4'b0111;
          3'b111:  dec = 4'b0000;
          3'b110:  dec = 4'b0001;
          3'b100:  dec = 4'b1100;
          3'b001:  dec = 4'b1001;
          3'b101:  dec = s_fun7 ? 4'b1011 : 4'b1010;
          default: dec = 4'b0010;
        endcase
      end
      default: dec = 4'b0010;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fire) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  if (resp_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= 4'b0010;
      id_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        owner_q <= gnt1;
        a_q     <= gnt1 ? req1_a  : req0_a;
        b_q     <= gnt1 ? req1_b  : req0_b;
        id_q    <= gnt1 ? req1_id : req0_id;
        ctrl_q  <= dec;
      end
      if (state_q == StIssue) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
    end
  end

  // ALU inputs only move at a handshake, so they hold outside ISSUE
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_q;

  assign resp0_valid  = (state_q == StResp) && !owner_q;
  assign resp1_valid  = (state_q == StResp) && owner_q;
  assign resp0_result = result_q;
  assign resp1_result = result_q;
  assign resp0_zero   = zero_q;
  assign resp1_zero   = zero_q;
  assign resp0_id     = id_q;
  assign resp1_id     = id_q;
  assign busy         = !idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural shared ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_aluop [2];
  logic [2:0]  req_fun3  [2];
  logic        req_fun7  [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic [3:0]  req_id    [2];
  logic        resp_valid  [2];
  logic        resp_ready  [2];
  logic [31:0] resp_result [2];
  logic        resp_zero   [2];
  logic [3:0]  resp_id     [2];
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1100: return a ^ b;
      4'b0111: return {31'd0, $signed(a) < $signed(b)};
      4'b1001: return a << b[4:0];
      4'b1010: return a >> b[4:0];
      4'b1011: return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  function automatic logic [3:0] exp_dec(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7);
    if (op == 2'b01) return (f3 == 3'b100 || f3 == 3'b101) ? 4'b0111 : 4'b0110;
    if (op == 2'b11) return 4'b0010;
    if (f3 == 3'b010) return 4'b0111;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b100) return 4'b1100;
    if (op == 2'b10 && f3 == 3'b000 && f7) return 4'b0110;
    if (op == 2'b10 && f3 == 3'b001) return 4'b1001;
    if (op == 2'b10 && f3 == 3'b101) return f7 ? 4'b1011 : 4'b1010;
    return 4'b0010;
  endfunction

  alu_share_arbiter #(.XLEN(32), .ID_W(4)) dut (
    .clk(clk), .reset(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_aluop(req_aluop[0]),
    .req0_fun3(req_fun3[0]), .req0_fun7(req_fun7[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req0_id(req_id[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_aluop(req_aluop[1]),
    .req1_fun3(req_fun3[1]), .req1_fun7(req_fun7[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .req1_id(req_id[1]),
    .resp0_valid(resp_valid[0]), .resp0_ready(resp_ready[0]), .resp0_result(resp_result[0]),
    .resp0_zero(resp_zero[0]), .resp0_id(resp_id[0]),
    .resp1_valid(resp_valid[1]), .resp1_ready(resp_ready[1]), .resp1_result(resp_result[1]),
    .resp1_zero(resp_zero[1]), .resp1_id(resp_id[1]),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_zero(alu_zero), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int who, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] id);
    req_aluop[who] = op; req_fun3[who] = f3; req_fun7[who] = f7;
    req_a[who] = a; req_b[who] = b; req_id[who] = id; req_valid[who] = 1'b1;
  endtask

  // Full solo transaction: handshake, ISSUE, RESP, back to IDLE
  task automatic run_op(input int who, input logic [1:0] op, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] id, input logic [3:0] ectrl, input string tag);
    logic [31:0] eres;
    eres = alu_model(ectrl, a, b);
    @(negedge clk);
    drive(who, op, f3, f7, a, b, id);
    #1 chk({tag, ".ready"}, {31'd0, req_ready[who]}, 32'd1);
    @(negedge clk);
    req_valid[who] = 1'b0;
    #1 chk({tag, ".ctrl"}, {28'd0, alu_ctrl}, {28'd0, ectrl});
    chk({tag, ".alu_a"}, alu_a, a);
    @(negedge clk);
    #1 chk({tag, ".rvalid"}, {31'd0, resp_valid[who]}, 32'd1);
    chk({tag, ".other"}, {31'd0, resp_valid[1-who]}, 32'd0);
    chk({tag, ".result"}, resp_result[who], eres);
    chk({tag, ".zero"}, {31'd0, resp_zero[who]}, {31'd0, eres == 32'd0});
    chk({tag, ".id"}, {28'd0, resp_id[who]}, {28'd0, id});
    resp_ready[who] = 1'b1;
    @(negedge clk);
    resp_ready[who] = 1'b0;
    #1 chk({tag, ".done"}, {30'd0, busy, resp_valid[who]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_aluop[i] = 0; req_fun3[i] = 0; req_fun7[i] = 0;
      req_a[i] = 0; req_b[i] = 0; req_id[i] = 0; resp_ready[i] = 0;
    end
    rst = 1'b1;
    #12;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.ctrl", {28'd0, alu_ctrl}, 32'h2);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.resp", {30'd0, resp_valid[1], resp_valid[0]}, 32'd0);
    chk("rst.id", {28'd0, resp_id[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // R-type SUB on req0; explicit result check
    run_op(0, 2'b10, 3'b000, 1'b1, 32'd10, 32'd3, 4'd5, 4'b0110, "sub");
    chk("sub.model", alu_model(4'b0110, 32'd10, 32'd3), 32'd7);

    // Fairness after reset: both valid continuously, grants alternate from req0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 2'b00, 3'b000, 1'b0, 32'd1, 32'd2, 4'd1);
    drive(1, 2'b00, 3'b100, 1'b0, 32'd6, 32'd6, 4'd2);
    resp_ready[0] = 1'b1; resp_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int own;
      own = k % 2;
      #1 chk("fair.gnt", {30'd0, req_ready[1], req_ready[0]}, (own == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      #1 chk("fair.busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      #1 chk("fair.resp", {30'd0, resp_valid[1], resp_valid[0]}, (own == 0) ? 32'd1 : 32'd2);
      chk("fair.id", {28'd0, resp_id[own]}, (own == 0) ? 32'd1 : 32'd2);
      chk("fair.zero", {31'd0, resp_zero[own]}, (own == 0) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    resp_ready[0] = 1'b0; resp_ready[1] = 1'b0;

    // Backpressure on resp1 while req0 waits
    @(negedge clk);
    drive(1, 2'b10, 3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 4'd9);
    #1 chk("bp.gnt1", {31'd0, req_ready[1]}, 32'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    drive(0, 2'b10, 3'b100, 1'b0, 32'h0000_00FF, 32'h0000_000F, 4'd3);
    #1 chk("bp.r0_issue", {31'd0, req_ready[0]}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp.valid", {31'd0, resp_valid[1]}, 32'd1);
      chk("bp.result", resp_result[1], 32'h00F0_0034);
      chk("bp.r0_ready", {31'd0, req_ready[0]}, 32'd0);
      @(negedge clk);
    end
    resp_ready[1] = 1'b1;
    @(negedge clk);
    resp_ready[1] = 1'b0;
    #1 chk("bp.r0_gnt", {31'd0, req_ready[0]}, 32'd1);
    chk("bp.r1_done", {31'd0, resp_valid[1]}, 32'd0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1 chk("bp.r0_ctrl", {28'd0, alu_ctrl}, 32'hC);
    @(negedge clk);
    #1 chk("bp.r0_resp", resp_result[0], 32'h0000_00F0);
    chk("bp.r0_valid", {31'd0, resp_valid[0]}, 32'd1);
    resp_ready[0] = 1'b1;
    @(negedge clk);
    resp_ready[0] = 1'b0;

    // Decode sweep through req1
    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int f7 = 0; f7 < 2; f7++)
          run_op(1, 2'(op), 3'(f3), 1'(f7), 32'h8000_0013, 32'h0000_0005, 4'(f3 + f7),
                 exp_dec(2'(op), 3'(f3), 1'(f7)), "dec");

    // Reset while in ISSUE drops the operation
    @(negedge clk);
    drive(0, 2'b10, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 4'd7);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1 chk("rmid.busy", {31'd0, busy}, 32'd0);
    chk("rmid.ctrl", {28'd0, alu_ctrl}, 32'h2);
    chk("rmid.alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rmid.noresp", {30'd0, resp_valid[1], resp_valid[0]}, 32'd0);
      @(negedge clk);
    end
    run_op(0, 2'b10, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 4'd7, 4'b1011, "rmid.next");

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 2'b00, 3'b000, 1'b0, 32'd4, 32'd5, 4'd1);
    drive(1, 2'b00, 3'b000, 1'b0, 32'd7, 32'd8, 4'd2);
    resp_ready[0] = 1'b1; resp_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("fix.gnt", {30'd0, req_ready[1], req_ready[0]}, 32'd1);
      @(negedge clk);
      #1 chk("fix.r1_ready", {31'd0, req_ready[1]}, 32'd0);
      @(negedge clk);
      #1 chk("fix.resp", {30'd0, resp_valid[1], resp_valid[0]}, 32'd1);
      @(negedge clk);
    end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    resp_ready[0] = 1'b0; resp_ready[1] = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
